stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Generates the 3-bit Stage code (1=Fetch..5=WriteBack, 0=idle) that drives the stage-enable decoder.
//  Run/halt/single-step FSM; one memory-stall hook; NOP forcing for the prime cycle.
//  Sits upstream of the enable decoder; sole owner of instruction timing in the multicycle core.
// PARAMETERS
//  CNT_W   16  width of Instr_Count (and Cycle_Count when enabled); wraps modulo 2^CNT_W
// PORTS
//  Clock        in   1      core clock, all state on rising edge
//  Reset        in   1      asynchronous, active-high; clears all state immediately
//  Run          in   1      level; 1=execute continuously, 0=stop at instruction boundary
//  Halt_Req     in   1      level; sampled only in Stage 5 of RUN
//  Step_Req     in   1      level; request one instruction from IDLE/HALTED
//  Step_Ack     out  1      1-cycle pulse in the cycle after a stepped instruction's Stage 5
//  Mem_Stall    in   1      holds the 3->4 transition while high
//  Stage        out  3      0=none, 1..5 as above; registered
//  NOP_Force    out  1      OR'd into decoder NOP_FLAG; high during the prime cycle
//  Instr_Done   out  1      1-cycle pulse in the cycle after each non-prime Stage 5
//  Seq_State    out  2      0=IDLE 1=RUN 2=STEP 3=HALTED
//  Instr_Count  out  CNT_W  completed instructions
//  Cycle_Count  out  CNT_W  see CONFIGURATION
// BEHAVIOUR
//  Reset values: Stage=0, NOP_Force=0, Step_Ack=0, Instr_Done=0, Seq_State=IDLE, counts=0.
//  Prime: first departure from IDLE after reset emits Stage=5 with NOP_Force=1 for exactly 1 cycle.
//    This loads IR from ROM with no RF/RAM write. Then 1,2,3,4,5,1... Later departures skip prime.
//  IDLE: Run=1 -> RUN (Run takes priority over Step_Req); else Step_Req=1 -> STEP. Stage=0.
//  RUN: Stage advances 1 per cycle 1->2->3->4->5->1.
//    At Stage 5: Halt_Req=1 -> HALTED; else Run=0 -> IDLE; else stay RUN. Halt beats Run=0.
//  STEP: exactly one instruction 1..5, then HALTED; Step_Ack pulses in the cycle after Stage 5.
//    Step_Req must drop before the next step is accepted (edge-qualified, not level-repeated).
//  HALTED: Stage=0. Step_Req rising -> STEP; Run=0 -> IDLE. Run staying 1 does not resume.
//  Stall: when internal stage=3 and Mem_Stall=1, Stage output=0 (all enables off); internal stage held.
//    First cycle with Mem_Stall=0 -> Stage=4. Stages 1,2,4,5 ignore Mem_Stall; no stage repeats.
//  Run=0 or Halt_Req mid-instruction: no effect until Stage 5; an instruction is never truncated.
//  Reset mid-instruction: outputs drop to reset values asynchronously.
//    Next run re-primes; the interrupted instruction is abandoned.
//  Instr_Done and Instr_Count++ in the cycle after each non-prime Stage 5. Counters wrap 2^CNT_W-1 -> 0.
// CONFIGURATION
//  CYCLE_COUNT_EN defined: Cycle_Count increments every cycle Seq_State is RUN or STEP, including stall cycles.
//  Undefined: Cycle_Count tied to 0; no counter flops.
// STRUCTURE
//  Shared header stage_defs.vh:
//    STG_NONE=0, STG_FETCH=1, STG_DECODE=2, STG_EXEC=3, STG_MEM=4, STG_WB=5;
//    SEQ_IDLE/RUN/STEP/HALTED encodings; included by this block and the enable decoder.
//  One sub-module: stage_counter (holds internal stage, advance/hold inputs, wraps 5->1).
//  FSM and counters stay in stage_sequencer.
// TESTING
//  1 Reset, Run=1 at cycle 2 -> Stage 0,5(NOP_Force=1),1,2,3,4,5,1; Instr_Done after 2nd 5; Instr_Count=1.
//  2 Mem_Stall=1 for 3 cycles from the cycle Stage=3 -> Stage 3,0,0,0,4,5; no repeated 3 or 4.
//  3 Halt_Req=1 during Stage 2 -> continues 3,4,5 then Stage=0, Seq_State=3; Run held 1 stays halted.
//  4 HALTED, Step_Req held 10 cycles -> exactly one 1..5, one Step_Ack, back to HALTED.
//    Drop and reassert -> second step.
//  5 Reset asserted mid-Stage 3 -> Stage=0 in the same cycle. Re-run re-primes with Stage=5 and NOP_Force=1.
//  6 CNT_W=4, 17 instructions -> Instr_Count wraps to 1. With CYCLE_COUNT_EN, Cycle_Count wraps too.
//    Without CYCLE_COUNT_EN, Cycle_Count stays 0.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: stage codes, sequencer states and stage-counter commands
package stage_sequencer_pkg;
  localparam logic [2:0] STG_NONE   = 3'd0;
  localparam logic [2:0] STG_FETCH  = 3'd1;
  localparam logic [2:0] STG_DECODE = 3'd2;
  localparam logic [2:0] STG_EXEC   = 3'd3;
  localparam logic [2:0] STG_MEM    = 3'd4;
  localparam logic [2:0] STG_WB     = 3'd5;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_STEP, SEQ_HALTED} seq_t;
  typedef enum logic [2:0] {CMD_HOLD, CMD_CLEAR, CMD_PRIME, CMD_START, CMD_ADVANCE} cmd_t;
  function automatic logic [2:0] next_stage(input logic [2:0] s);
    return s == STG_WB ? STG_FETCH : s + 3'd1;
  endfunction
endpackage

// File: rtl/stage_counter.sv
// stage_counter: internal stage register plus the registered Stage output it drives
//   clock/reset : core clock, asynchronous active-high reset
//   cmd         : hold / clear / prime (load 5) / start (load 1) / advance
//   mem_stall   : holds the 3->4 advance while high
//   cur         : internal stage (survives a stall)
//   stage       : visible stage code, forced to 0 while stalled
module stage_counter
  import stage_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  cmd_t       cmd,
  input  logic       mem_stall,
  output logic [2:0] cur,
  output logic [2:0] stage
);
  logic       stall;
  logic [2:0] nxt;
  always_comb begin
    stall = cmd == CMD_ADVANCE && cur == STG_EXEC && mem_stall;
    nxt = cmd == CMD_CLEAR ? STG_NONE :
          cmd == CMD_PRIME ? STG_WB :
          cmd == CMD_START ? STG_FETCH :
          cmd == CMD_ADVANCE && !stall ? next_stage(cur) : cur;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cur   <= STG_NONE;
      stage <= STG_NONE;
    end else begin
      cur   <= nxt;
      stage <= stall ? STG_NONE : nxt;
    end
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: run/halt/single-step sequencer producing the stage code for the enable decoder
//   clock/reset          : core clock, asynchronous active-high reset
//   run/halt_req/step_req: control levels; mem_stall holds the 3->4 transition
//   stage/nop_force      : stage code (0 idle, 1..5) and prime-cycle NOP
//   instr_done/step_ack  : pulses after each completed (stepped) instruction
//   seq_state            : 0 IDLE 1 RUN 2 STEP 3 HALTED
//   instr_count/cycle_count : wrapping counters; cycle_count only with CYCLE_COUNT_EN
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             mem_stall,
  output logic             step_ack,
  output logic [2:0]       stage,
  output logic             nop_force,
  output logic             instr_done,
  output logic [1:0]       seq_state,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);
  seq_t       state, nstate;
  cmd_t       cmd;
  logic [2:0] cur;
  logic       primed, armed, active, done, go_step, launch, accept, leave;
  stage_counter u_cnt (
    .clock(clock), .reset(reset), .cmd(cmd), .mem_stall(mem_stall), .cur(cur), .stage(stage)
  );
  // The prime cycle shows stage 5 but is not an instruction boundary.
  always_comb begin
    active  = state == SEQ_RUN || state == SEQ_STEP;
    done    = active && !nop_force && cur == STG_WB;
    go_step = step_req && armed;
    launch  = state == SEQ_IDLE ? run || go_step : state == SEQ_HALTED && go_step;
    accept  = go_step && (state == SEQ_HALTED || (state == SEQ_IDLE && !run));
    leave   = done && (state == SEQ_STEP || halt_req || !run);
    cmd = launch ? (primed ? CMD_START : CMD_PRIME) :
          !active ? CMD_HOLD :
          nop_force ? CMD_START :
          leave ? CMD_CLEAR : CMD_ADVANCE;
    nstate = state == SEQ_IDLE ? (run ? SEQ_RUN : go_step ? SEQ_STEP : SEQ_IDLE) :
             state == SEQ_HALTED ? (go_step ? SEQ_STEP : !run ? SEQ_IDLE : SEQ_HALTED) :
             !done ? state :
             state == SEQ_STEP || halt_req ? SEQ_HALTED :
             !run ? SEQ_IDLE : SEQ_RUN;
  end
  // armed re-arms only once step_req has been seen low, so a held request steps once.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= SEQ_IDLE;
      primed      <= 1'b0;
      armed       <= 1'b1;
      nop_force   <= 1'b0;
      instr_done  <= 1'b0;
      step_ack    <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= nstate;
      primed      <= primed || launch;
      armed       <= !step_req || (armed && !accept);
      nop_force   <= launch && !primed;
      instr_done  <= done;
      step_ack    <= done && state == SEQ_STEP;
      instr_count <= instr_count + CNT_W'(done);
    end
  assign seq_state = state;
`ifdef CYCLE_COUNT_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) cycle_count <= '0;
    else if (active) cycle_count <= cycle_count + CNT_W'(1);
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: scoreboard bench for stage_sequencer
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;
  localparam int W = 4;
  logic clock = 1'b0, reset = 1'b1, run = 1'b0, halt_req = 1'b0, step_req = 1'b0, mem_stall = 1'b0;
  logic step_ack, nop_force, instr_done;
  logic [2:0] stage;
  logic [1:0] seq_state;
  logic [W-1:0] instr_count, cycle_count;
  int tests = 0, failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  stage_sequencer #(.CNT_W(W)) dut (
    .clock(clock), .reset(reset), .run(run), .halt_req(halt_req), .step_req(step_req),
    .mem_stall(mem_stall), .step_ack(step_ack), .stage(stage), .nop_force(nop_force),
    .instr_done(instr_done), .seq_state(seq_state), .instr_count(instr_count),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ob(input logic [2:0] s, input logic n, input logic d,
                                    input logic a, input logic [1:0] q);
    return {s, n, d, a, q};
  endfunction

  function automatic logic [7:0] obs();
    return {stage, nop_force, instr_done, step_ack, seq_state};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    tests++;
    if (obs() !== ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_IDLE)) begin
      failed++;
      $display("FAIL reset_outputs got %h exp %h", obs(), ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_IDLE));
    end
    tests++;
    if (instr_count !== '0) begin failed++; $display("FAIL reset_instr_count got %0d exp 0", instr_count); end
    tests++;
    if (cycle_count !== '0) begin failed++; $display("FAIL reset_cycle_count got %0d exp 0", cycle_count); end
    reset = 1'b0;
  endtask

  task automatic test_prime;
    exp_q.push_back(ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_IDLE));
    while (exp_q.size() > 0) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL prime_idle got %h exp %h", obs(), e); end
    end
    run = 1'b1;
    exp_q.push_back(ob(3'd5, 1'b1, 1'b0, 1'b0, SEQ_RUN));
    for (int s = 1; s <= 5; s++) exp_q.push_back(ob(3'(s), 1'b0, 1'b0, 1'b0, SEQ_RUN));
    exp_q.push_back(ob(3'd1, 1'b0, 1'b1, 1'b0, SEQ_RUN));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL prime_seq cyc%0d got %h exp %h", i, obs(), e); end
    end
    tests++;
    if (instr_count !== W'(1)) begin failed++; $display("FAIL prime_count got %0d exp 1", instr_count); end
  endtask

  task automatic test_stall;
    exp_q.push_back(ob(3'd2, 1'b0, 1'b0, 1'b0, SEQ_RUN));
    exp_q.push_back(ob(3'd3, 1'b0, 1'b0, 1'b0, SEQ_RUN));
    while (exp_q.size() > 0) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL stall_pre got %h exp %h", obs(), e); end
    end
    mem_stall = 1'b1;
    repeat (3) exp_q.push_back(ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_RUN));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL stall_hold cyc%0d got %h exp %h", i, obs(), e); end
    end
    mem_stall = 1'b0;
    exp_q.push_back(ob(3'd4, 1'b0, 1'b0, 1'b0, SEQ_RUN));
    exp_q.push_back(ob(3'd5, 1'b0, 1'b0, 1'b0, SEQ_RUN));
    exp_q.push_back(ob(3'd1, 1'b0, 1'b1, 1'b0, SEQ_RUN));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL stall_release cyc%0d got %h exp %h", i, obs(), e); end
    end
    tests++;
    if (instr_count !== W'(2)) begin failed++; $display("FAIL stall_count got %0d exp 2", instr_count); end
  endtask

  task automatic test_halt;
    exp_q.push_back(ob(3'd2, 1'b0, 1'b0, 1'b0, SEQ_RUN));
    while (exp_q.size() > 0) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL halt_pre got %h exp %h", obs(), e); end
    end
    halt_req = 1'b1;
    for (int s = 3; s <= 5; s++) exp_q.push_back(ob(3'(s), 1'b0, 1'b0, 1'b0, SEQ_RUN));
    exp_q.push_back(ob(3'd0, 1'b0, 1'b1, 1'b0, SEQ_HALTED));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL halt_finish cyc%0d got %h exp %h", i, obs(), e); end
    end
    halt_req = 1'b0;
    repeat (3) exp_q.push_back(ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_HALTED));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL halt_stays cyc%0d got %h exp %h", i, obs(), e); end
    end
    tests++;
    if (instr_count !== W'(3)) begin failed++; $display("FAIL halt_count got %0d exp 3", instr_count); end
  endtask

  task automatic test_step;
    step_req = 1'b1;
    for (int s = 1; s <= 5; s++) exp_q.push_back(ob(3'(s), 1'b0, 1'b0, 1'b0, SEQ_STEP));
    exp_q.push_back(ob(3'd0, 1'b0, 1'b1, 1'b1, SEQ_HALTED));
    repeat (4) exp_q.push_back(ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_HALTED));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL step_held cyc%0d got %h exp %h", i, obs(), e); end
    end
    step_req = 1'b0;
    exp_q.push_back(ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_HALTED));
    while (exp_q.size() > 0) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL step_drop got %h exp %h", obs(), e); end
    end
    step_req = 1'b1;
    for (int s = 1; s <= 5; s++) exp_q.push_back(ob(3'(s), 1'b0, 1'b0, 1'b0, SEQ_STEP));
    exp_q.push_back(ob(3'd0, 1'b0, 1'b1, 1'b1, SEQ_HALTED));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL step_again cyc%0d got %h exp %h", i, obs(), e); end
    end
    step_req = 1'b0;
    tests++;
    if (instr_count !== W'(5)) begin failed++; $display("FAIL step_count got %0d exp 5", instr_count); end
  endtask

  task automatic test_reset_mid;
    run = 1'b0;
    exp_q.push_back(ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_IDLE));
    while (exp_q.size() > 0) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL rst_mid_idle got %h exp %h", obs(), e); end
    end
    run = 1'b1;
    for (int s = 1; s <= 3; s++) exp_q.push_back(ob(3'(s), 1'b0, 1'b0, 1'b0, SEQ_RUN));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL rst_mid_run cyc%0d got %h exp %h", i, obs(), e); end
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (obs() !== ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_IDLE)) begin
      failed++;
      $display("FAIL rst_mid_async got %h exp %h", obs(), ob(3'd0, 1'b0, 1'b0, 1'b0, SEQ_IDLE));
    end
    tests++;
    if (instr_count !== '0) begin failed++; $display("FAIL rst_mid_count got %0d exp 0", instr_count); end
    tick;
    reset = 1'b0;
    exp_q.push_back(ob(3'd5, 1'b1, 1'b0, 1'b0, SEQ_RUN));
    exp_q.push_back(ob(3'd1, 1'b0, 1'b0, 1'b0, SEQ_RUN));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick; e = exp_q.pop_front(); tests++;
      if (obs() !== e) begin failed++; $display("FAIL rst_mid_reprime cyc%0d got %h exp %h", i, obs(), e); end
    end
  endtask

  task automatic test_wrap;
    logic [W-1:0] ecc;
    reset = 1'b1;
    run = 1'b1;
    tick;
    reset = 1'b0;
    exp_q.push_back(ob(3'd5, 1'b1, 1'b0, 1'b0, SEQ_RUN));
    tick; e = exp_q.pop_front(); tests++;
    if (obs() !== e) begin failed++; $display("FAIL wrap_prime got %h exp %h", obs(), e); end
    for (int n = 1; n <= 17; n++)
      for (int s = 1; s <= 5; s++) begin
        exp_q.push_back(ob(3'(s), 1'b0, s == 1 && n > 1, 1'b0, SEQ_RUN));
        tick; e = exp_q.pop_front(); tests++;
        if (obs() !== e) begin failed++; $display("FAIL wrap_seq n%0d s%0d got %h exp %h", n, s, obs(), e); end
        if (s == 1) begin
          tests++;
          if (instr_count !== W'(n - 1)) begin
            failed++;
            $display("FAIL wrap_count n%0d got %0d exp %0d", n, instr_count, W'(n - 1));
          end
        end
      end
    exp_q.push_back(ob(3'd1, 1'b0, 1'b1, 1'b0, SEQ_RUN));
    tick; e = exp_q.pop_front(); tests++;
    if (obs() !== e) begin failed++; $display("FAIL wrap_last got %h exp %h", obs(), e); end
    tests++;
    if (instr_count !== W'(1)) begin failed++; $display("FAIL wrap_final_count got %0d exp 1", instr_count); end
`ifdef CYCLE_COUNT_EN
    ecc = W'(86);
`else
    ecc = '0;
`endif
    tests++;
    if (cycle_count !== ecc) begin failed++; $display("FAIL wrap_cycle_count got %0d exp %0d", cycle_count, ecc); end
    run = 1'b0;
  endtask

  initial begin
    test_reset;
    test_prime;
    test_stall;
    test_halt;
    test_step;
    test_reset_mid;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
